iob_ethmac_ctrl: RTL and testbench
==================================

// Module: iob_ethmac_ctrl
// PURPOSE
// Hardware sequencer that configures and runs the Ethernet MAC through its native iob slave port, with no CPU involvement.
// On a start pulse it writes MODER, the RX and TX buffer descriptors, the enables and INT_MASK, then services interrupts.
// It clears interrupt sources and returns the RX descriptor status word. Sits between system control logic and the ethmac wrapper.
// PARAMETERS
// ADDR_W       12      iob address width (byte address)
// DATA_W       32      iob data width; only 32 is supported
// TIMEOUT_W    20      width of the completion timeout counter
// TIMEOUT_CYC  500000  clk_i cycles allowed from the end of the INT_MASK write to RXB seen
// PORTS
// clk_i          in   1         system clock
// arst_n_i       in   1         asynchronous active-low reset
// start_i        in   1         1-cycle pulse; launches a sequence; ignored while busy_o=1
// loopback_i     in   1         sampled at start; sets MODER bit7
// fduplex_i      in   1         sampled at start; sets MODER bit10
// tx_len_i       in   16        sampled at start; TX frame length, goes to TX BD [31:16]
// tx_ptr_i       in   32        sampled at start; TX buffer pointer
// rx_ptr_i       in   32        sampled at start; RX buffer pointer
// busy_o         out  1         high from the cycle after start until done_o or err_o
// done_o         out  1         1-cycle pulse on successful reception
// err_o          out  1         level; stays high until the next accepted start
// err_code_o     out  2         1=TXE, 2=RXE, 3=timeout
// rx_bd_o        out  32        RX BD word read at the end of the sequence
// int_seen_o     out  7         OR of all INT_SOURCE values read in this sequence
// m_valid_o      out  1         iob master request
// m_address_o    out  ADDR_W    iob master address
// m_wdata_o      out  DATA_W    iob master write data
// m_wstrb_o      out  DATA_W/8  4'hf = write, 0 = read
// m_rdata_i      in   DATA_W    iob read data; valid in the m_ready_i cycle
// m_ready_i      in   1         iob transaction complete
// eth_int_i      in   1         ethmac interrupt line (level)
// BEHAVIOUR
// Reset: every output is 0, FSM is IDLE, timeout counter is 0.
// Asynchronous reset mid-transaction drops m_valid_o at once; the MAC is expected to be reset with the controller.
// Bus handshake:
//   - One transaction outstanding at a time.
//   - m_valid_o, m_address_o, m_wdata_o and m_wstrb_o are registered and held stable until m_ready_i=1.
//   - The cycle after m_ready_i, m_valid_o is 0 for at least one cycle.
//   - rdata is captured in the m_ready_i cycle.
// Write sequence (each state issues one transaction and advances on m_ready_i):
//   1. WR_MODER   0x000 <- 0xA000 | lb<<7 | fd<<10
//   2. WR_RXPTR   0x604 <- rx_ptr
//   3. WR_RXBD    0x600 <- 0x0000E000
//   4. WR_TXPTR   0x404 <- tx_ptr
//   5. WR_TXBD    0x400 <- {tx_len, 16'hF000}
//   6. WR_EN      0x000 <- MODER | 0x3
//   7. WR_MASK    0x008 <- 0x7F
//   8. then go to WAIT_IRQ
// Interrupt service:
//   - WAIT_IRQ: wait for eth_int_i=1, then go to RD_INT.
//   - RD_INT: read 0x004 and OR the value into int_seen_o.
//       - read value 0: return to WAIT_IRQ.
//       - otherwise: go to CLR_INT.
//   - CLR_INT: write the read value back to 0x004 (W1C), then branch on the value read:
//       - TXE (bit1) set: ERR, code 1.
//       - else RXE (bit3) set: ERR, code 2.
//       - else RXB (bit2) set: RD_RXBD.
//       - else: WAIT_IRQ.
//   - RD_RXBD: read 0x600 into rx_bd_o, then DONE.
//   - DONE: pulse done_o, return to IDLE.
// Timeout:
//   - The counter starts at 0 when the WR_MASK write completes and increments every cycle in WAIT_IRQ, RD_INT and CLR_INT.
//   - It reaches TIMEOUT_CYC while in WAIT_IRQ: go to ERR with code 3.
//   - It reaches TIMEOUT_CYC during RD_INT or CLR_INT: that bus transaction completes first, then ERR with code 3.
//   - No bus transaction is ever abandoned.
//   - The counter saturates and never wraps.
// ERR: one cycle; err_o goes high, busy_o goes low, then IDLE.
// Start handling:
//   - start_i in IDLE clears err_o, err_code_o and int_seen_o; rx_bd_o holds its value until it is overwritten.
//   - start_i in the DONE or ERR cycle is ignored.
// Simultaneous events: eth_int_i rising during a bus transaction is seen in WAIT_IRQ afterwards, because the line is level-sensitive.
// STRUCTURE
// Shared header iob_ethmac_ctrl.vh:
//   - register offsets (MODER 0x000, INT_SRC 0x004, INT_MASK 0x008, TXBD 0x400/0x404, RXBD 0x600/0x604)
//   - MODER bits, BD control words, INT bit indices, FSM state encodings, error codes
// Sub-module iob_ethmac_ctrl_bus: single-outstanding iob master (request/ack/rdata capture). The FSM stays in the top.
// TESTING
// T1 reset: arst_n_i=0 mid-WR_TXBD -> m_valid_o=0 immediately; all outputs 0 after release.
// T2 write order: start with lb=1, fd=1, len=0x20, tx_ptr=0, rx_ptr=0x80, slave ready after 3 cycles ->
//     - writes: 0x000=A480, 0x604=80, 0x600=E000, 0x404=0, 0x400=0020F000, 0x000=A483, 0x008=7F
//     - valid stays stable until ready
// T3 success: INT_SRC reads 0x1, then 0x4 -> W1C writes 0x1 and 0x4; RXBD read 0x00406000 -> rx_bd_o=0x00406000, done_o pulse, int_seen_o=0x05.
// T4 RX error: INT_SRC reads 0x8 -> W1C 0x8, err_o=1, err_code_o=2, no RXBD read.
// T5 timeout: TIMEOUT_CYC=100 and eth_int_i never asserted -> err_code_o=3 exactly 100 cycles after the WR_MASK ack.
// T6 start while busy_o=1 -> ignored; a new start after done_o replays the T2 write sequence.

Source files
------------

// File: rtl/iob_ethmac_ctrl_pkg.sv
// Shared constants for the ethmac sequencer: register map, MODER/BD control
// words, interrupt bit positions, error codes and FSM state encoding.
package iob_ethmac_ctrl_pkg;

   // ethmac register offsets (byte addresses on the iob slave port)
   localparam logic [11:0] ADDR_MODER    = 12'h000;
   localparam logic [11:0] ADDR_INT_SRC  = 12'h004;
   localparam logic [11:0] ADDR_INT_MASK = 12'h008;
   localparam logic [11:0] ADDR_TX_BD    = 12'h400;
   localparam logic [11:0] ADDR_TX_PTR   = 12'h404;
   localparam logic [11:0] ADDR_RX_BD    = 12'h600;
   localparam logic [11:0] ADDR_RX_PTR   = 12'h604;

   // MODER: pad + CRC enable base, loopback/full-duplex options, RX/TX enable
   localparam logic [31:0] MODER_BASE         = 32'h0000_A000;
   localparam int          MODER_LOOPBACK_BIT = 7;
   localparam int          MODER_FDUPLEX_BIT  = 10;
   localparam logic [31:0] MODER_RXTX_EN      = 32'h0000_0003;

   // buffer descriptor control words
   localparam logic [31:0] RX_BD_CTRL   = 32'h0000_E000;
   localparam logic [15:0] TX_BD_CTRL   = 16'hF000;
   localparam logic [31:0] INT_MASK_ALL = 32'h0000_007F;

   // INT_SOURCE bit positions
   localparam int INT_TXE_BIT = 1;
   localparam int INT_RXB_BIT = 2;
   localparam int INT_RXE_BIT = 3;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TXE     = 2'd1,
      ERR_RXE     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_MODER = 4'd1,
      ST_WR_RXPTR = 4'd2,
      ST_WR_RXBD  = 4'd3,
      ST_WR_TXPTR = 4'd4,
      ST_WR_TXBD  = 4'd5,
      ST_WR_EN    = 4'd6,
      ST_WR_MASK  = 4'd7,
      ST_WAIT_IRQ = 4'd8,
      ST_RD_INT   = 4'd9,
      ST_CLR_INT  = 4'd10,
      ST_RD_RXBD  = 4'd11,
      ST_DONE     = 4'd12,
      ST_ERR      = 4'd13
   } state_t;

   // MODER value before the RX/TX enables are set
   function automatic logic [31:0] moder_word(input logic lb, input logic fd);
      logic [31:0] w;
      w = MODER_BASE;
      w[MODER_LOOPBACK_BIT] = lb;
      w[MODER_FDUPLEX_BIT]  = fd;
      return w;
   endfunction

endpackage

// File: rtl/iob_ethmac_ctrl_bus.sv
// Single-outstanding iob master. A request is accepted only while no
// transaction is in flight; the request fields are registered and held until
// the slave answers, after which valid drops for at least one cycle.
module iob_ethmac_ctrl_bus #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                req,
   input  logic [ADDR_W-1:0]   req_address,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                req_write,
   output logic                ack,
   output logic [DATA_W-1:0]   rdata,
   output logic                idle,
   output logic                m_valid_o,
   output logic [ADDR_W-1:0]   m_address_o,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   input  logic [DATA_W-1:0]   m_rdata_i,
   input  logic                m_ready_i
);

   // read data is only meaningful in the ack cycle; the caller captures it
   assign ack   = m_valid_o & m_ready_i;
   assign rdata = m_rdata_i;
   assign idle  = ~m_valid_o;

   // launch on request, hold until ready, then release for a cycle
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         m_valid_o   <= 1'b0;
         m_address_o <= '0;
         m_wdata_o   <= '0;
         m_wstrb_o   <= '0;
      end else if (ack) begin
         m_valid_o <= 1'b0;
      end else if (req && !m_valid_o) begin
         m_valid_o   <= 1'b1;
         m_address_o <= req_address;
         m_wdata_o   <= req_wdata;
         m_wstrb_o   <= req_write ? '1 : '0;
      end
   end

endmodule

// File: rtl/iob_ethmac_ctrl.sv
// Ethernet MAC sequencer: programs MODER, the RX/TX descriptors, the enables
// and INT_MASK over the iob port, then services interrupts until a frame is
// received, an error is flagged or the completion timeout expires.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for start_i
//   WR_MODER | MODER <- base | loopback | full duplex
//   WR_RXPTR | RX BD pointer word
//   WR_RXBD  | RX BD control word (empty, wrap, irq)
//   WR_TXPTR | TX BD pointer word
//   WR_TXBD  | TX BD {length, ready/irq/wrap/pad}
//   WR_EN    | MODER with RX and TX enabled
//   WR_MASK  | INT_MASK <- all sources; timeout counter restarts
//   WAIT_IRQ | wait for eth_int_i or timeout
//   RD_INT   | read INT_SOURCE
//   CLR_INT  | write INT_SOURCE value back (W1C), then branch on it
//   RD_RXBD  | read RX BD status word
//   DONE     | done_o pulse
//   ERR      | err_o raised, one cycle
module iob_ethmac_ctrl
   import iob_ethmac_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_W   = 20,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                start_i,
   input  logic                loopback_i,
   input  logic                fduplex_i,
   input  logic [15:0]         tx_len_i,
   input  logic [31:0]         tx_ptr_i,
   input  logic [31:0]         rx_ptr_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [1:0]          err_code_o,
   output logic [31:0]         rx_bd_o,
   output logic [6:0]          int_seen_o,
   output logic                m_valid_o,
   output logic [ADDR_W-1:0]   m_address_o,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   input  logic [DATA_W-1:0]   m_rdata_i,
   input  logic                m_ready_i,
   input  logic                eth_int_i
);

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

   state_t                state;
   logic                  lb_q;
   logic                  fd_q;
   logic [15:0]           tx_len_q;
   logic [31:0]           tx_ptr_q;
   logic [31:0]           rx_ptr_q;
   logic [DATA_W-1:0]     int_val_q;
   logic [TIMEOUT_W-1:0]  tmo_cnt;

   logic                  issue;
   logic                  bus_req;
   logic                  bus_write;
   logic [ADDR_W-1:0]     bus_address;
   logic [DATA_W-1:0]     bus_wdata;
   logic                  bus_ack;
   logic                  bus_idle;
   logic [DATA_W-1:0]     bus_rdata;
   logic                  tmo_run;
   logic                  tmo_hit;

   // tmo_hit means the counter reaches TIMEOUT_CYC on this edge (or already has)
   assign tmo_run = (state == ST_WAIT_IRQ) || (state == ST_RD_INT) || (state == ST_CLR_INT);
   assign tmo_hit = (tmo_cnt >= TMO_LAST);
   assign bus_req = issue & bus_idle;

   // bus request contents for the current state
   always_comb begin
      issue       = 1'b0;
      bus_write   = 1'b0;
      bus_address = '0;
      bus_wdata   = '0;
      case (state)
         ST_WR_MODER: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_MODER);
            bus_wdata   = DATA_W'(moder_word(lb_q, fd_q));
         end
         ST_WR_RXPTR: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_RX_PTR);
            bus_wdata   = DATA_W'(rx_ptr_q);
         end
         ST_WR_RXBD: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_RX_BD);
            bus_wdata   = DATA_W'(RX_BD_CTRL);
         end
         ST_WR_TXPTR: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_TX_PTR);
            bus_wdata   = DATA_W'(tx_ptr_q);
         end
         ST_WR_TXBD: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_TX_BD);
            bus_wdata   = DATA_W'({tx_len_q, TX_BD_CTRL});
         end
         ST_WR_EN: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_MODER);
            bus_wdata   = DATA_W'(moder_word(lb_q, fd_q) | MODER_RXTX_EN);
         end
         ST_WR_MASK: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_INT_MASK);
            bus_wdata   = DATA_W'(INT_MASK_ALL);
         end
         ST_RD_INT: begin
            issue       = 1'b1;
            bus_address = ADDR_W'(ADDR_INT_SRC);
         end
         ST_CLR_INT: begin
            issue       = 1'b1;
            bus_write   = 1'b1;
            bus_address = ADDR_W'(ADDR_INT_SRC);
            bus_wdata   = int_val_q;
         end
         ST_RD_RXBD: begin
            issue       = 1'b1;
            bus_address = ADDR_W'(ADDR_RX_BD);
         end
         default: ;
      endcase
   end

   iob_ethmac_ctrl_bus #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bus (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .req         (bus_req),
      .req_address (bus_address),
      .req_wdata   (bus_wdata),
      .req_write   (bus_write),
      .ack         (bus_ack),
      .rdata       (bus_rdata),
      .idle        (bus_idle),
      .m_valid_o   (m_valid_o),
      .m_address_o (m_address_o),
      .m_wdata_o   (m_wdata_o),
      .m_wstrb_o   (m_wstrb_o),
      .m_rdata_i   (m_rdata_i),
      .m_ready_i   (m_ready_i)
   );

   // sequencer: state, registered status outputs and the saturating timeout counter
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state      <= ST_IDLE;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
         rx_bd_o    <= '0;
         int_seen_o <= '0;
         lb_q       <= 1'b0;
         fd_q       <= 1'b0;
         tx_len_q   <= '0;
         tx_ptr_q   <= '0;
         rx_ptr_q   <= '0;
         int_val_q  <= '0;
         tmo_cnt    <= '0;
      end else begin
         done_o <= 1'b0;
         if (tmo_run && (tmo_cnt != TMO_MAX)) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);

         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  lb_q       <= loopback_i;
                  fd_q       <= fduplex_i;
                  tx_len_q   <= tx_len_i;
                  tx_ptr_q   <= tx_ptr_i;
                  rx_ptr_q   <= rx_ptr_i;
                  err_o      <= 1'b0;
                  err_code_o <= ERR_NONE;
                  int_seen_o <= '0;
                  busy_o     <= 1'b1;
                  state      <= ST_WR_MODER;
               end
            end
            ST_WR_MODER: if (bus_ack) state <= ST_WR_RXPTR;
            ST_WR_RXPTR: if (bus_ack) state <= ST_WR_RXBD;
            ST_WR_RXBD:  if (bus_ack) state <= ST_WR_TXPTR;
            ST_WR_TXPTR: if (bus_ack) state <= ST_WR_TXBD;
            ST_WR_TXBD:  if (bus_ack) state <= ST_WR_EN;
            ST_WR_EN:    if (bus_ack) state <= ST_WR_MASK;
            ST_WR_MASK: begin
               if (bus_ack) begin
                  tmo_cnt <= '0;
                  state   <= ST_WAIT_IRQ;
               end
            end
            ST_WAIT_IRQ: begin
               if (tmo_hit) begin
                  err_o      <= 1'b1;
                  err_code_o <= ERR_TIMEOUT;
                  busy_o     <= 1'b0;
                  state      <= ST_ERR;
               end else if (eth_int_i) begin
                  state <= ST_RD_INT;
               end
            end
            ST_RD_INT: begin
               if (bus_ack) begin
                  int_seen_o <= int_seen_o | bus_rdata[6:0];
                  int_val_q  <= bus_rdata;
                  if (tmo_hit) begin
                     err_o      <= 1'b1;
                     err_code_o <= ERR_TIMEOUT;
                     busy_o     <= 1'b0;
                     state      <= ST_ERR;
                  end else if (bus_rdata == '0) begin
                     state <= ST_WAIT_IRQ;
                  end else begin
                     state <= ST_CLR_INT;
                  end
               end
            end
            ST_CLR_INT: begin
               if (bus_ack) begin
                  if (tmo_hit) begin
                     err_o      <= 1'b1;
                     err_code_o <= ERR_TIMEOUT;
                     busy_o     <= 1'b0;
                     state      <= ST_ERR;
                  end else if (int_val_q[INT_TXE_BIT]) begin
                     err_o      <= 1'b1;
                     err_code_o <= ERR_TXE;
                     busy_o     <= 1'b0;
                     state      <= ST_ERR;
                  end else if (int_val_q[INT_RXE_BIT]) begin
                     err_o      <= 1'b1;
                     err_code_o <= ERR_RXE;
                     busy_o     <= 1'b0;
                     state      <= ST_ERR;
                  end else if (int_val_q[INT_RXB_BIT]) begin
                     state <= ST_RD_RXBD;
                  end else begin
                     state <= ST_WAIT_IRQ;
                  end
               end
            end
            ST_RD_RXBD: begin
               if (bus_ack) begin
                  rx_bd_o <= bus_rdata[31:0];
                  done_o  <= 1'b1;
                  busy_o  <= 1'b0;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_ethmac_ctrl.sv
// Self-checking bench for iob_ethmac_ctrl: an iob slave model with
// configurable latency answers the controller, and a transaction-level
// reference model predicts the bus log and the final status.
`timescale 1ns/1ps
module tb_iob_ethmac_ctrl;

   localparam int TMO = 100;

   typedef struct packed {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic        loopback = 1'b0;
   logic        fduplex = 1'b0;
   logic [15:0] tx_len = '0;
   logic [31:0] tx_ptr = '0;
   logic [31:0] rx_ptr = '0;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [31:0] rx_bd;
   logic [6:0]  int_seen;
   logic        m_valid;
   logic [11:0] m_address;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] m_rdata = '0;
   logic        m_ready = 1'b0;
   logic        eth_int = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // slave model state
   int          lat = 1;
   bit          in_txn = 1'b0;
   bit          prev_ready = 1'b0;
   int          wcnt = 0;
   txn_t        cur;
   logic [3:0]  cur_strb;
   int          stable_err = 0;
   int          gap_err = 0;
   int          mask_ack_cyc = -1;
   logic [31:0] rxbd_val = '0;
   txn_t        got_q[$];
   logic [31:0] int_q[$];

   // reference model
   logic [31:0] int_plan[$];
   txn_t        exp_q[$];
   int          exp_done;
   logic [1:0]  exp_code;
   logic [6:0]  exp_seen;

   iob_ethmac_ctrl #(
      .ADDR_W(12), .DATA_W(32), .TIMEOUT_W(20), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_i(clk), .arst_n_i(arst_n), .start_i(start), .loopback_i(loopback),
      .fduplex_i(fduplex), .tx_len_i(tx_len), .tx_ptr_i(tx_ptr), .rx_ptr_i(rx_ptr),
      .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
      .rx_bd_o(rx_bd), .int_seen_o(int_seen), .m_valid_o(m_valid),
      .m_address_o(m_address), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
      .m_rdata_i(m_rdata), .m_ready_i(m_ready), .eth_int_i(eth_int)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // iob slave: answers after `lat` extra cycles, checks stability and the release gap
   initial begin : slave
      forever begin
         @(negedge clk);
         m_ready = 1'b0;
         m_rdata = '0;
         if (prev_ready && m_valid) gap_err++;
         prev_ready = 1'b0;
         if (m_valid) begin
            if (!in_txn) begin
               in_txn   = 1'b1;
               wcnt     = 0;
               cur.wr   = (m_wstrb == 4'hf);
               cur.addr = m_address;
               cur.data = m_wdata;
               cur_strb = m_wstrb;
            end else if (cur.addr !== m_address || cur.data !== m_wdata || cur_strb !== m_wstrb) begin
               stable_err++;
            end
            if (wcnt >= lat) begin
               m_ready    = 1'b1;
               prev_ready = 1'b1;
               in_txn     = 1'b0;
               if (!cur.wr) begin
                  if (cur.addr == 12'h004) begin
                     if (int_q.size() > 0) m_rdata = int_q.pop_front();
                     else m_rdata = 32'h0;
                  end else if (cur.addr == 12'h600) m_rdata = rxbd_val;
                  else m_rdata = 32'hDEAD_BEEF;
                  cur.data = m_rdata;
               end else if (cur.addr == 12'h008) begin
                  mask_ack_cyc = cyc + 1;
               end
               got_q.push_back(cur);
            end else begin
               wcnt++;
            end
         end
      end
   end

   // expected transaction log and outcome, from the register-programming rules
   task automatic build_model(input logic lb, input logic fd, input logic [15:0] len,
                              input logic [31:0] txp, input logic [31:0] rxp, input bit irq_on);
      logic [31:0] moder;
      logic [31:0] v;
      moder = 32'hA000 + (lb ? 32'h80 : 32'h0) + (fd ? 32'h400 : 32'h0);
      exp_q.delete();
      exp_q.push_back({1'b1, 12'h000, moder});
      exp_q.push_back({1'b1, 12'h604, rxp});
      exp_q.push_back({1'b1, 12'h600, 32'h0000E000});
      exp_q.push_back({1'b1, 12'h404, txp});
      exp_q.push_back({1'b1, 12'h400, len, 16'hF000});
      exp_q.push_back({1'b1, 12'h000, moder + 32'h3});
      exp_q.push_back({1'b1, 12'h008, 32'h7F});
      exp_done = 0;
      exp_code = 2'd0;
      exp_seen = 7'd0;
      if (!irq_on) begin
         exp_code = 2'd3;
         return;
      end
      for (int i = 0; i < int_plan.size(); i++) begin
         v = int_plan[i];
         exp_q.push_back({1'b0, 12'h004, v});
         exp_seen = exp_seen | v[6:0];
         if (v == 0) continue;
         exp_q.push_back({1'b1, 12'h004, v});
         if (v[1]) begin exp_code = 2'd1; return; end
         if (v[3]) begin exp_code = 2'd2; return; end
         if (v[2]) begin
            exp_q.push_back({1'b0, 12'h600, rxbd_val});
            exp_done = 1;
            return;
         end
      end
   endtask

   // drives one sequence to completion and collects what happened
   task automatic run_seq(input logic lb, input logic fd, input logic [15:0] len,
                          input logic [31:0] txp, input logic [31:0] rxp,
                          input bit irq_on, input bit poke,
                          output int n_done, output bit finished, output int busy_bad,
                          output bit busy_end, output int late_act, output int end_cyc);
      got_q.delete();
      int_q = int_plan;
      stable_err = 0;
      gap_err = 0;
      n_done = 0; finished = 1'b0; busy_bad = 0; busy_end = 1'b1; late_act = 0; end_cyc = 0;
      @(negedge clk);
      loopback = lb; fduplex = fd; tx_len = len; tx_ptr = txp; rx_ptr = rxp;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      eth_int = irq_on;
      for (int i = 0; i < 3000 && !finished; i++) begin
         if (done) n_done++;
         if (done || err) begin
            finished = 1'b1;
            busy_end = busy;
            end_cyc  = cyc;
         end else begin
            if (!busy) busy_bad++;
            if (poke && i == 5) begin
               start = 1'b1; tx_len = ~len; loopback = ~lb; rx_ptr = ~rxp;
            end else if (poke && i == 6) begin
               start = 1'b0; tx_len = len; loopback = lb; rx_ptr = rxp;
            end
            @(negedge clk);
         end
      end
      start = poke;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
         if (done) n_done++;
         if (busy || m_valid) late_act++;
      end
      eth_int = 1'b0;
   endtask

   task automatic test_reset();
      #23;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({done, err, err_code} !== 4'b0) begin errors++; $display("FAIL reset_status got=%b exp=0", {done, err, err_code}); end
      checks++; if ({rx_bd, int_seen} !== 39'b0) begin errors++; $display("FAIL reset_data got=%h exp=0", {rx_bd, int_seen}); end
      checks++; if ({m_valid, m_address, m_wdata, m_wstrb} !== 49'b0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {m_valid, m_address, m_wdata, m_wstrb}); end
      @(posedge clk); #2 arst_n = 1'b1;
   endtask

   task automatic test_write_order();
      int nd, bb, la, ec; bit fin, be;
      lat = 3; rxbd_val = $urandom;
      int_plan = '{32'h4};
      build_model(1'b1, 1'b1, 16'h0020, 32'h0, 32'h80, 1'b1);
      run_seq(1'b1, 1'b1, 16'h0020, 32'h0, 32'h80, 1'b1, 1'b0, nd, fin, bb, be, la, ec);
      checks++; if (got_q.size() < 7) begin errors++; $display("FAIL wr_order_count got=%0d exp>=7", got_q.size()); end
      for (int i = 0; i < 7 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wr_order_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (stable_err !== 0) begin errors++; $display("FAIL wr_stable got=%0d exp=0", stable_err); end
      checks++; if (gap_err !== 0) begin errors++; $display("FAIL wr_gap got=%0d exp=0", gap_err); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL wr_busy_low got=%0d exp=0", bb); end
   endtask

   task automatic test_success();
      int nd, bb, la, ec; bit fin, be;
      lat = 1; rxbd_val = 32'h0040_6000;
      int_plan = '{32'h1, 32'h4};
      build_model(1'b0, 1'b1, 16'h05EE, 32'h1000, 32'h2000, 1'b1);
      run_seq(1'b0, 1'b1, 16'h05EE, 32'h1000, 32'h2000, 1'b1, 1'b0, nd, fin, bb, be, la, ec);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL succ_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL succ_txn_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (nd !== 1) begin errors++; $display("FAIL succ_done got=%0d exp=1", nd); end
      checks++; if (rx_bd !== 32'h0040_6000) begin errors++; $display("FAIL succ_rxbd got=%h exp=00406000", rx_bd); end
      checks++; if (int_seen !== 7'h05) begin errors++; $display("FAIL succ_seen got=%h exp=05", int_seen); end
      checks++; if ({err, busy_end_chk(be)} !== 2'b00) begin errors++; $display("FAIL succ_err_busy got=%b exp=00", {err, be}); end
   endtask

   function automatic logic busy_end_chk(input bit be);
      return be;
   endfunction

   task automatic test_rx_error();
      int nd, bb, la, ec; bit fin, be;
      lat = 2; rxbd_val = 32'h1234_5678;
      int_plan = '{32'h8};
      build_model(1'b1, 1'b0, 16'h0100, 32'hA0, 32'hB0, 1'b1);
      run_seq(1'b1, 1'b0, 16'h0100, 32'hA0, 32'hB0, 1'b1, 1'b0, nd, fin, bb, be, la, ec);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rxe_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rxe_txn_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if ({err, err_code} !== 3'b110) begin errors++; $display("FAIL rxe_code got=%b exp=110", {err, err_code}); end
      checks++; if (rx_bd !== 32'h0040_6000) begin errors++; $display("FAIL rxe_rxbd_hold got=%h exp=00406000", rx_bd); end
      checks++; if (nd !== 0 || be !== 1'b0 || la !== 0) begin errors++; $display("FAIL rxe_done_busy got=%0d/%b/%0d exp=0/0/0", nd, be, la); end
   endtask

   task automatic test_busy_start();
      int nd, bb, la, ec; bit fin, be;
      lat = 1; rxbd_val = $urandom;
      int_plan = '{32'h4};
      build_model(1'b0, 1'b0, 16'h0040, 32'h300, 32'h400, 1'b1);
      run_seq(1'b0, 1'b0, 16'h0040, 32'h300, 32'h400, 1'b1, 1'b1, nd, fin, bb, be, la, ec);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL busy_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_txn_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (nd !== 1) begin errors++; $display("FAIL busy_done got=%0d exp=1", nd); end
      checks++; if (la !== 0) begin errors++; $display("FAIL busy_start_in_done got=%0d exp=0", la); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL busy_err_cleared got=%b exp=0", err); end
   endtask

   task automatic test_timeout_idle();
      int nd, bb, la, ec; bit fin, be;
      lat = 0;
      int_plan.delete();
      build_model(1'b1, 1'b0, 16'h0010, 32'h10, 32'h20, 1'b0);
      run_seq(1'b1, 1'b0, 16'h0010, 32'h10, 32'h20, 1'b0, 1'b0, nd, fin, bb, be, la, ec);
      checks++; if ({err, err_code} !== 3'b111) begin errors++; $display("FAIL tmo_code got=%b exp=111", {err, err_code}); end
      checks++; if (ec - mask_ack_cyc !== TMO) begin errors++; $display("FAIL tmo_cycles got=%0d exp=%0d", ec - mask_ack_cyc, TMO); end
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL tmo_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      checks++; if (be !== 1'b0 || nd !== 0) begin errors++; $display("FAIL tmo_busy_done got=%b/%0d exp=0/0", be, nd); end
   endtask

   task automatic test_timeout_bus();
      int nd, bb, la, ec; bit fin, be;
      lat = 2;
      int_plan.delete();
      run_seq(1'b0, 1'b1, 16'h0010, 32'h10, 32'h20, 1'b1, 1'b0, nd, fin, bb, be, la, ec);
      checks++; if ({err, err_code} !== 3'b111) begin errors++; $display("FAIL tmob_code got=%b exp=111", {err, err_code}); end
      checks++; if (ec - mask_ack_cyc < TMO || ec - mask_ack_cyc > TMO + 10) begin errors++; $display("FAIL tmob_cycles got=%0d exp=%0d..%0d", ec - mask_ack_cyc, TMO, TMO + 10); end
      checks++; if (in_txn !== 1'b0 || m_valid !== 1'b0 || la !== 0) begin errors++; $display("FAIL tmob_abandon got=%b/%b/%0d exp=0/0/0", in_txn, m_valid, la); end
      checks++; if (int_seen !== 7'h0) begin errors++; $display("FAIL tmob_seen got=%h exp=00", int_seen); end
   endtask

   task automatic test_random();
      int nd, bb, la, ec; bit fin, be;
      logic lb, fd; logic [15:0] len; logic [31:0] txp, rxp;
      int n;
      for (int it = 0; it < 8; it++) begin
         lat = $urandom_range(0, 3);
         lb = 1'($urandom); fd = 1'($urandom); len = 16'($urandom);
         txp = $urandom; rxp = $urandom; rxbd_val = $urandom;
         int_plan.delete();
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) int_plan.push_back($urandom & 32'h71);
         int_plan.push_back(($urandom & 32'h7F) | (32'h1 << $urandom_range(1, 3)));
         build_model(lb, fd, len, txp, rxp, 1'b1);
         run_seq(lb, fd, len, txp, rxp, 1'b1, 1'b0, nd, fin, bb, be, la, ec);
         checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_len got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_txn_%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
         end
         checks++; if (err_code !== exp_code || err !== (exp_code != 0)) begin errors++; $display("FAIL rnd%0d_code got=%b/%0d exp=%0d", it, err, err_code, exp_code); end
         checks++; if (nd !== exp_done) begin errors++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, nd, exp_done); end
         checks++; if (int_seen !== exp_seen) begin errors++; $display("FAIL rnd%0d_seen got=%h exp=%h", it, int_seen, exp_seen); end
         if (exp_done == 1) begin
            checks++; if (rx_bd !== rxbd_val) begin errors++; $display("FAIL rnd%0d_rxbd got=%h exp=%h", it, rx_bd, rxbd_val); end
         end
         checks++; if (stable_err + gap_err + bb + la !== 0) begin errors++; $display("FAIL rnd%0d_proto got=%0d/%0d/%0d/%0d exp=0", it, stable_err, gap_err, bb, la); end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      lat = 5;
      int_plan = '{32'h4};
      int_q = int_plan;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (m_valid && m_address == 12'h400) seen = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach got=0 exp=1"); end
      @(posedge clk);
      #2 arst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", m_valid); end
      in_txn = 1'b0; prev_ready = 1'b0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 arst_n = 1'b1;
      @(negedge clk);
      checks++; if ({busy, done, err, err_code} !== 5'b0) begin errors++; $display("FAIL rstmid_status got=%b exp=0", {busy, done, err, err_code}); end
      checks++; if ({rx_bd, int_seen} !== 39'b0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", {rx_bd, int_seen}); end
      checks++; if ({m_valid, m_wstrb} !== 5'b0) begin errors++; $display("FAIL rstmid_bus got=%b exp=0", {m_valid, m_wstrb}); end
   endtask

   initial begin
      test_reset();
      test_write_order();
      test_success();
      test_rx_error();
      test_busy_start();
      test_timeout_idle();
      test_timeout_bus();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
